libhdl_ocmem_dp_cc_be: RTL and testbench
========================================

Name: libhdl_ocmem_dp_cc_be

Overview:
- Common-clock true dual-port on-chip memory with per-byte write enables, per-port access enables and per-port read-latency pipelines.
- Read-valid tracking on each port; detection and defined resolution of same-address collisions.
- Drop-in successor for register files, packet buffers and descriptor tables that need partial-word writes and latency-matched valid strobes.

Parameters:
- W, 32, data word width in bits; must be a multiple of BW.
- BW, 8, byte-lane width in bits; NB = W/BW lanes.
- D, 1024, depth in words; address width AW = $clog2(D).
- MODEA, "READ_FIRST", port A write-cycle output: "READ_FIRST", "WRITE_FIRST" or "NO_CHANGE".
- MODEB, "READ_FIRST", port B write-cycle output mode; same legal values as MODEA.
- OREGA, 0, extra output register stages on port A, 0..4; read latency LA = 1+OREGA.
- OREGB, 0, extra output register stages on port B, 0..4; LB = 1+OREGB.
- INIT_FILE, "", hex file loaded into the array at elaboration if non-empty.

Ports:
- i_clk  in  1  clock; all logic on the rising edge.
- i_rst  in  1  synchronous reset, active-high.
- i_ena  in  1  port A access enable.
- i_wea  in  NB  port A byte write enables; only effective with i_ena=1.
- i_addra  in  AW  port A word address.
- i_wdata  in  W  port A write data.
- o_rdata  out  W  port A read data.
- o_rvalida  out  1  port A read data valid, one pulse per qualifying access.
- i_enb, i_web, i_addrb, i_wdatb, o_rdatb, o_rvalidb: port B equivalents, same widths.
- o_coll  out  1  one-cycle pulse, registered, flags a collision in the previous cycle.
- o_coll_sticky  out  1  set on any collision; cleared only by reset.

Behaviour:
- Reset values: o_rdata, o_rdatb, all pipeline stages = 0; o_rvalida, o_rvalidb, all valid stages = 0; o_coll = 0; o_coll_sticky = 0.
- Reset does not clear the array.
- An access presented while i_rst=1 is ignored: no write, no valid.
- Reset mid-flight discards all in-flight reads; no valid is emitted for them after reset releases.
- Access types per port:
  - Idle: en=0. No array change. The output stage-1 register holds. Later pipeline stages still shift.
  - Read: en=1, we=0. Data = mem[addr].
  - Write: en=1, we!=0. Each byte lane k with we[k]=1 is written from wdata[k*BW+:BW]; lanes with we[k]=0 are unchanged.
- Stage-1 output on a write:
  - READ_FIRST: the old word.
  - WRITE_FIRST: the merged word (new lanes where we=1, old lanes otherwise).
  - NO_CHANGE: the stage-1 register holds.
- Valid: a read, or a write in READ_FIRST/WRITE_FIRST mode, produces exactly one rvalid pulse LA (or LB) cycles after the access cycle, aligned with its data. A NO_CHANGE write produces no valid.
- Back-to-back accesses give one result per cycle with no bubbles. Pipeline registers shift every cycle; the data path is not stalled by idles.
- Collision condition: ena=1, enb=1, addra==addrb, and (wea!=0 or web!=0).
  - o_coll pulses the next cycle; o_coll_sticky sets the next cycle.
- Collision resolution:
  - Both ports write: for lanes both enabled, port B data is stored. Disjoint lanes each take their own port's data.
  - One port reads while the other writes: the reader returns the pre-write word.
  - A writing port in WRITE_FIRST returns its own merged word. It does not include the other port's lanes.
- Two reads of the same address: no collision; both return the same word.
- Address range: addresses >= D when D is not a power of two. Writes are dropped and reads return 0, but rvalid still pulses.
- Parameter checks: elaboration error if W%BW!=0, OREGx>4, or MODEx is illegal.

Test Plan:
All cases use W=32, BW=8, D=16, OREGA=0, OREGB=1, MODEA=READ_FIRST, MODEB=WRITE_FIRST.
1. Reset released; A writes 0xA1B2C3D4 to addr 3 with wea=4'hF; next cycle B reads addr 3 -> o_rdatb=0xA1B2C3D4 with o_rvalidb=1 exactly 2 cycles after the B read; o_rvalida pulses 1 cycle after the write with the old value 0.
2. Byte lanes: mem[5]=0x11223344; B writes 0xAABBCCDD with web=4'b0101 -> o_rdatb=0x11BB33DD after 2 cycles; a later A read of addr 5 returns 0x11BB33DD at latency 1.
3. Dual-write collision: both write addr 7 in the same cycle, A=0x0000FFFF with wea=4'hF, B=0x12345678 with web=4'b0011 -> mem[7]=0x00005678; o_coll=1 the next cycle only; o_coll_sticky stays 1.
4. Read/write collision: mem[2]=0xCAFEF00D; A reads addr 2 while B writes 0xDEADBEEF -> o_rdata=0xCAFEF00D; o_rdatb=0xDEADBEEF; o_coll pulses; a later read returns 0xDEADBEEF.
5. Streaming: A reads addrs 0..15 on 16 consecutive cycles -> 16 consecutive rvalida pulses with matching data; idle cycles produce rvalida=0 and o_rdata held.
6. Reset mid-flight: B read issued, i_rst=1 on the next cycle -> o_rvalidb never pulses for it; outputs are 0; o_coll_sticky is cleared; array contents persist.

Source files
------------

// File: rtl/libhdl_ocmem_dp_cc_be.sv
`default_nettype none
// ============================================================================
// Module      : libhdl_ocmem_dp_cc_be
// Description : Common-clock true dual-port RAM with byte write enables,
//               per-port read-latency pipelines, read-valid strobes and
//               same-address collision detection.
// Revision    : 1.0 - initial release
// ============================================================================
module libhdl_ocmem_dp_cc_be #(
    parameter int    W         = 32,
    parameter int    BW        = 8,
    parameter int    D         = 1024,
    parameter string MODEA     = "READ_FIRST",
    parameter string MODEB     = "READ_FIRST",
    parameter int    OREGA     = 0,
    parameter int    OREGB     = 0,
    parameter string INIT_FILE = "",
    localparam int   C_NB      = W / BW,
    localparam int   C_AW      = (D > 1) ? $clog2(D) : 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_ena,
    input  logic [C_NB-1:0] i_wea,
    input  logic [C_AW-1:0] i_addra,
    input  logic [W-1:0]    i_wdata,
    output logic [W-1:0]    o_rdata,
    output logic            o_rvalida,
    input  logic            i_enb,
    input  logic [C_NB-1:0] i_web,
    input  logic [C_AW-1:0] i_addrb,
    input  logic [W-1:0]    i_wdatb,
    output logic [W-1:0]    o_rdatb,
    output logic            o_rvalidb,
    output logic            o_coll,
    output logic            o_coll_sticky
);

    localparam logic [1:0] C_RF = 2'd0;
    localparam logic [1:0] C_WF = 2'd1;
    localparam logic [1:0] C_NC = 2'd2;

    localparam logic [1:0] C_MODEA = (MODEA == "WRITE_FIRST") ? C_WF :
                                     (MODEA == "NO_CHANGE")   ? C_NC : C_RF;
    localparam logic [1:0] C_MODEB = (MODEB == "WRITE_FIRST") ? C_WF :
                                     (MODEB == "NO_CHANGE")   ? C_NC : C_RF;

    if (W % BW != 0) begin : g_bad_width
        $error("libhdl_ocmem_dp_cc_be: W must be a multiple of BW");
    end
    if (OREGA < 0 || OREGA > 4 || OREGB < 0 || OREGB > 4) begin : g_bad_oreg
        $error("libhdl_ocmem_dp_cc_be: OREGA/OREGB must be in 0..4");
    end
    if (!(MODEA == "READ_FIRST" || MODEA == "WRITE_FIRST" || MODEA == "NO_CHANGE") ||
        !(MODEB == "READ_FIRST" || MODEB == "WRITE_FIRST" || MODEB == "NO_CHANGE"))
    begin : g_bad_mode
        $error("libhdl_ocmem_dp_cc_be: illegal MODEA/MODEB");
    end

    logic [W-1:0] r_mem [D];

    // ---------------------------------------------------------------------------
    // Access qualification (reset masks all accesses)
    // ---------------------------------------------------------------------------
    logic         w_acc_a, w_wr_a, w_inr_a, w_ld_a;
    logic         w_acc_b, w_wr_b, w_inr_b, w_ld_b;
    logic [W-1:0] w_old_a, w_mrg_a, w_d1_a;
    logic [W-1:0] w_old_b, w_mrg_b, w_d1_b;
    logic         w_coll;

    assign w_acc_a = i_ena & ~i_rst;
    assign w_acc_b = i_enb & ~i_rst;
    assign w_wr_a  = w_acc_a & (|i_wea);
    assign w_wr_b  = w_acc_b & (|i_web);
    assign w_inr_a = 32'(i_addra) < 32'(D);
    assign w_inr_b = 32'(i_addrb) < 32'(D);
    assign w_old_a = w_inr_a ? r_mem[i_addra] : '0;
    assign w_old_b = w_inr_b ? r_mem[i_addrb] : '0;

    // Merged word reflects only this port's own lanes over the pre-write word
    always_comb begin
        w_mrg_a = w_old_a;
        w_mrg_b = w_old_b;
        for (int k = 0; k < C_NB; k++) begin
            if (i_wea[k]) w_mrg_a[k*BW +: BW] = i_wdata[k*BW +: BW];
            if (i_web[k]) w_mrg_b[k*BW +: BW] = i_wdatb[k*BW +: BW];
        end
        if (!w_inr_a) w_mrg_a = '0;
        if (!w_inr_b) w_mrg_b = '0;
    end

    assign w_ld_a = w_acc_a & ~(w_wr_a & (C_MODEA == C_NC));
    assign w_ld_b = w_acc_b & ~(w_wr_b & (C_MODEB == C_NC));
    assign w_d1_a = (w_wr_a && (C_MODEA == C_WF)) ? w_mrg_a : w_old_a;
    assign w_d1_b = (w_wr_b && (C_MODEB == C_WF)) ? w_mrg_b : w_old_b;

    // ---------------------------------------------------------------------------
    // Array write; port B is applied last so it owns shared lanes
    // ---------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        for (int k = 0; k < C_NB; k++) begin
            if (w_wr_a && w_inr_a && i_wea[k])
                r_mem[i_addra][k*BW +: BW] <= i_wdata[k*BW +: BW];
            if (w_wr_b && w_inr_b && i_web[k])
                r_mem[i_addrb][k*BW +: BW] <= i_wdatb[k*BW +: BW];
        end
    end

    // ---------------------------------------------------------------------------
    // Output pipelines: stage 0 loads on a qualifying access, later stages shift
    // ---------------------------------------------------------------------------
    logic [W-1:0]   r_pd_a [OREGA+1];
    logic [OREGA:0] r_pv_a;
    logic [W-1:0]   r_pd_b [OREGB+1];
    logic [OREGB:0] r_pv_b;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i <= OREGA; i++) r_pd_a[i] <= '0;
            r_pv_a <= '0;
        end else begin
            if (w_ld_a) r_pd_a[0] <= w_d1_a;
            r_pv_a[0] <= w_ld_a;
            for (int i = 1; i <= OREGA; i++) begin
                r_pd_a[i] <= r_pd_a[i-1];
                r_pv_a[i] <= r_pv_a[i-1];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i <= OREGB; i++) r_pd_b[i] <= '0;
            r_pv_b <= '0;
        end else begin
            if (w_ld_b) r_pd_b[0] <= w_d1_b;
            r_pv_b[0] <= w_ld_b;
            for (int i = 1; i <= OREGB; i++) begin
                r_pd_b[i] <= r_pd_b[i-1];
                r_pv_b[i] <= r_pv_b[i-1];
            end
        end
    end

    assign o_rdata   = r_pd_a[OREGA];
    assign o_rvalida = r_pv_a[OREGA];
    assign o_rdatb   = r_pd_b[OREGB];
    assign o_rvalidb = r_pv_b[OREGB];

    // ---------------------------------------------------------------------------
    // Collision flags
    // ---------------------------------------------------------------------------
    assign w_coll = w_acc_a & w_acc_b & (i_addra == i_addrb) & (w_wr_a | w_wr_b);

    logic r_coll, r_coll_sticky;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_coll        <= 1'b0;
            r_coll_sticky <= 1'b0;
        end else begin
            r_coll        <= w_coll;
            r_coll_sticky <= r_coll_sticky | w_coll;
        end
    end

    assign o_coll        = r_coll;
    assign o_coll_sticky = r_coll_sticky;

endmodule
`default_nettype wire

// File: tb/tb_libhdl_ocmem_dp_cc_be.sv
`default_nettype none
// ============================================================================
// Module      : tb_libhdl_ocmem_dp_cc_be
// Description : Scoreboard bench for the dual-port byte-enable RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_libhdl_ocmem_dp_cc_be;

  localparam int LA = 1;
  localparam int LB = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ena = 1'b0, enb = 1'b0;
  logic [3:0]  wea = '0, web = '0, addra = '0, addrb = '0;
  logic [31:0] wdata = '0, wdatb = '0;
  logic [31:0] o_rdata, o_rdatb;
  logic        o_rvalida, o_rvalidb, o_coll, o_coll_sticky;

  always #5 clk = ~clk;

  libhdl_ocmem_dp_cc_be #(
    .W(32), .BW(8), .D(16),
    .MODEA("READ_FIRST"), .MODEB("WRITE_FIRST"),
    .OREGA(0), .OREGB(1), .INIT_FILE("")
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_ena(ena), .i_wea(wea), .i_addra(addra), .i_wdata(wdata),
    .o_rdata(o_rdata), .o_rvalida(o_rvalida),
    .i_enb(enb), .i_web(web), .i_addrb(addrb), .i_wdatb(wdatb),
    .o_rdatb(o_rdatb), .o_rvalidb(o_rvalidb),
    .o_coll(o_coll), .o_coll_sticky(o_coll_sticky)
  );

  typedef struct {int at; logic [31:0] d; bit chk;} exp_t;
  exp_t qa[$], qb[$];
  int   qc[$];
  int   cyc = 0;
  logic rst_q = 1'b1;
  int   n_vec = 0, n_bad = 0;
  bit   started = 1'b0, sticky_exp = 1'b0, coll_exp;
  exp_t e;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rst_q <= rst;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s (cycle %0d): got %h, expected %h", nm, cyc, act, req);
    end
  endtask

  // Monitor: pops expected responses whenever the DUT presents a valid
  always @(negedge clk) begin
    if (started) begin
      while (qa.size() > 0 && qa[0].at < cyc) begin
        void'(qa.pop_front()); n_vec++; n_bad++;
        $display("FAIL rvalida_missing (cycle %0d): got 0, expected 1", cyc);
      end
      if (o_rvalida) begin
        if (qa.size() == 0 || qa[0].at != cyc) begin
          n_vec++; n_bad++;
          $display("FAIL rvalida_unexpected (cycle %0d): got 1, expected 0", cyc);
        end else begin
          e = qa.pop_front();
          if (e.chk) check("rdata_a", o_rdata, e.d);
        end
      end
      while (qb.size() > 0 && qb[0].at < cyc) begin
        void'(qb.pop_front()); n_vec++; n_bad++;
        $display("FAIL rvalidb_missing (cycle %0d): got 0, expected 1", cyc);
      end
      if (o_rvalidb) begin
        if (qb.size() == 0 || qb[0].at != cyc) begin
          n_vec++; n_bad++;
          $display("FAIL rvalidb_unexpected (cycle %0d): got 1, expected 0", cyc);
        end else begin
          e = qb.pop_front();
          if (e.chk) check("rdata_b", o_rdatb, e.d);
        end
      end
      coll_exp = 1'b0;
      if (rst_q) sticky_exp = 1'b0;
      if (qc.size() > 0 && qc[0] == cyc) begin
        void'(qc.pop_front());
        coll_exp   = 1'b1;
        sticky_exp = 1'b1;
      end
      check("coll", {31'b0, o_coll}, {31'b0, coll_exp});
      check("coll_sticky", {31'b0, o_coll_sticky}, {31'b0, sticky_exp});
    end
  end

  // One access cycle on both ports; expected responses are queued up front
  task automatic drive(input logic ea, input logic [3:0] wa, input logic [3:0] aa,
                       input logic [31:0] da, input logic [31:0] xa, input bit ca,
                       input logic eb, input logic [3:0] wb, input logic [3:0] ab,
                       input logic [31:0] db, input logic [31:0] xb, input bit cb,
                       input bit coll);
    ena = ea; wea = wa; addra = aa; wdata = da;
    enb = eb; web = wb; addrb = ab; wdatb = db;
    if (ea && !rst) qa.push_back('{cyc + LA, xa, ca});
    if (eb && !rst) qb.push_back('{cyc + LB, xb, cb});
    if (coll) qc.push_back(cyc + 1);
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    drive(0, 4'h0, 4'h0, 32'h0, 32'h0, 0, 0, 4'h0, 4'h0, 32'h0, 32'h0, 0, 0);
  endtask

  task automatic rd_a(input logic [3:0] a, input logic [31:0] x);
    drive(1, 4'h0, a, 32'h0, x, 1, 0, 4'h0, 4'h0, 32'h0, 32'h0, 0, 0);
  endtask

  task automatic rd_b(input logic [3:0] a, input logic [31:0] x);
    drive(0, 4'h0, 4'h0, 32'h0, 32'h0, 0, 1, 4'h0, a, 32'h0, x, 1, 0);
  endtask

  function automatic logic [31:0] stream_exp(input int i);
    case (i)
      2:       stream_exp = 32'hDEADBEEF;
      3:       stream_exp = 32'hA1B2C3D4;
      5:       stream_exp = 32'h11BB33DD;
      7:       stream_exp = 32'h00005678;
      default: stream_exp = 32'h01010101 * 32'(i);
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] v;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    started = 1'b1;
    check("reset_rdata",    o_rdata,   32'h0);
    check("reset_rdatb",    o_rdatb,   32'h0);
    check("reset_rvalida",  {31'b0, o_rvalida}, 32'h0);
    check("reset_rvalidb",  {31'b0, o_rvalidb}, 32'h0);
    check("reset_coll",     {31'b0, o_coll}, 32'h0);
    check("reset_sticky",   {31'b0, o_coll_sticky}, 32'h0);

    // Known contents: addr i = i*0x01010101, addr 3 = 0
    for (int i = 0; i < 16; i++) begin
      v = (i == 3) ? 32'h0 : 32'h01010101 * 32'(i);
      drive(0, 4'h0, 4'h0, 32'h0, 32'h0, 0, 1, 4'hF, 4'(i), v, v, 1, 0);
    end
    drive(1, 4'hF, 4'd5, 32'h11223344, 32'h05050505, 1,
          1, 4'hF, 4'd2, 32'hCAFEF00D, 32'hCAFEF00D, 1, 0);

    // 1: full write on A (read-first returns old), then B read at latency 2
    drive(1, 4'hF, 4'd3, 32'hA1B2C3D4, 32'h0, 1, 0, 4'h0, 4'h0, 32'h0, 32'h0, 0, 0);
    rd_b(4'd3, 32'hA1B2C3D4);

    // 2: partial-lane write on B (write-first returns merged word)
    drive(0, 4'h0, 4'h0, 32'h0, 32'h0, 0, 1, 4'b0101, 4'd5, 32'hAABBCCDD, 32'h11BB33DD, 1, 0);
    rd_a(4'd5, 32'h11BB33DD);

    // 3: dual write collision, B owns shared lanes
    drive(1, 4'hF, 4'd7, 32'h0000FFFF, 32'h07070707, 1,
          1, 4'b0011, 4'd7, 32'h12345678, 32'h07075678, 1, 1);
    rd_a(4'd7, 32'h00005678);
    idle();

    // 4: A reads while B writes the same word
    drive(1, 4'h0, 4'd2, 32'h0, 32'hCAFEF00D, 1,
          1, 4'hF, 4'd2, 32'hDEADBEEF, 32'hDEADBEEF, 1, 1);
    drive(1, 4'h0, 4'd2, 32'h0, 32'hDEADBEEF, 1,
          1, 4'h0, 4'd2, 32'h0, 32'hDEADBEEF, 1, 0);

    // 5: streaming reads, then idle holds the last word
    for (int i = 0; i < 16; i++) rd_a(4'(i), stream_exp(i));
    idle();
    check("idle_hold_rdata", o_rdata, 32'h0F0F0F0F);
    idle();
    check("sticky_before_rst", {31'b0, o_coll_sticky}, 32'h1);

    // 6: reset right after a B read; access during reset is ignored
    rd_b(4'd4, 32'h04040404);
    rst = 1'b1;
    qb.delete();
    drive(1, 4'hF, 4'd4, 32'hFFFFFFFF, 32'h0, 0, 0, 4'h0, 4'h0, 32'h0, 32'h0, 0, 0);
    idle();
    rst = 1'b0;
    check("rst_rdata",   o_rdata,   32'h0);
    check("rst_rdatb",   o_rdatb,   32'h0);
    check("rst_rvalidb", {31'b0, o_rvalidb}, 32'h0);
    check("rst_sticky",  {31'b0, o_coll_sticky}, 32'h0);
    idle();
    rd_a(4'd4, 32'h04040404);
    rd_b(4'd3, 32'hA1B2C3D4);

    repeat (4) idle();
    if (qa.size() != 0 || qb.size() != 0) begin
      n_vec++; n_bad++;
      $display("FAIL drain: got %0d/%0d pending, expected 0/0", qa.size(), qb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
